signed_addsub_pipe: RTL and testbench
=====================================

# signed_addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with signed-overflow detection and an optional per-transaction saturation mode. It generalises the fixed 8-bit combinational signed adder to any `WIDTH`. The carry chain is split into `SEG`-bit carry-lookahead segments, one pipeline stage per segment. It sits on datapath streams behind a valid/ready handshake, accepts one operation per cycle and applies backpressure.

## Interface
- `WIDTH`, 32: operand/result width in bits; must be a multiple of `SEG` and ≥ 2.
- `SEG`, 8: segment width per pipeline stage; `NSEG = WIDTH/SEG` stages.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: input operation valid.
- `in_ready` out 1: block can accept an input this cycle.
- `in_a` in `WIDTH`: signed operand A.
- `in_b` in `WIDTH`: signed operand B.
- `in_sub` in 1: 1 computes A−B; 0 computes A+B.
- `in_sat` in 1: 1 clamps the result on overflow; 0 wraps it.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out `WIDTH`: result.
- `out_ovf` out 1: signed overflow occurred, reported whether or not saturation was applied.

## Operation
- Effective B is `in_sub ? ~in_b : in_b`. Carry-in to segment 0 is `in_sub`.
- Stage k (0..NSEG−1) adds segment k of A and effective B with the carry registered from stage k−1. Upper segments of the operands and `in_sub`/`in_sat` are skew-delayed alongside; lower result segments are carried forward.
- The final stage computes `ovf = c_into_msb XOR c_out_msb`. This equals: the operand signs match (A and effective B) and the result sign differs.
- Wrap mode (`sat=0`): `out_sum` is the wrapped sum mod 2^WIDTH.
- Saturate mode with `ovf=1`: `out_sum` is the max positive (0x7F..F) if A's sign bit is 0, otherwise the min negative (0x80..0).
- Saturate mode with `ovf=0`: `out_sum` is the wrapped sum.
- The carry-out of the MSB is not exported.
- Each stage holds a valid bit. Bubbles propagate without gaps being compacted.

## Timing
- Latency is exactly `NSEG` cycles from input acceptance (`in_valid && in_ready` at edge t) to `out_valid=1` after edge t+NSEG−1, when there is no stall.
- Throughput is 1 operation per cycle.
- Global advance is `adv = !out_valid || out_ready`. `in_ready = adv`, combinational from `out_ready` and the registered `out_valid`.
- When `adv=0`, every stage register, including outputs, holds its value. `out_sum`/`out_ovf` stay stable while `out_valid && !out_ready`.
- Inputs presented with `in_ready=0` are ignored; the source must hold them.
- If `out_ready` drops for N cycles, nothing is lost or duplicated and order is preserved.
- Reset (`rst_n=0`, asynchronous) forces all stage valids, `out_valid`, `out_sum` and `out_ovf` to 0. `in_ready` therefore reads 1.
- In-flight operations at reset are discarded. The first input accepted after deassertion sees normal latency.
- Simultaneous accept and output on the same edge is the normal streaming case, with no extra bubble.

## Structure
- Package `signed_add_pkg` holds:
  - the helpers `sat_max(WIDTH)`/`sat_min(WIDTH)`;
  - the elaboration check `WIDTH % SEG == 0`;
  - the default `SEG`.
- Sub-module `cla_segment`: a combinational `SEG`-bit carry-lookahead adder built from generate/propagate with lookahead carries. It has inputs a, b, cin and outputs sum, cout and c_msb_in (carry into its top bit). It is instantiated `NSEG` times by generate.
- The top level contains the skew/pipeline registers, the valid chain, stall control and the saturation mux.

## Test plan
All scenarios use `WIDTH=16`, `SEG=8`, so latency is 2.
- `0x7FFF + 0x0001`, sat=0 → `0x8000`, ovf=1. With sat=1 → `0x7FFF`, ovf=1.
- `0x8000 − 0x0001`, sat=0 → `0x7FFF`, ovf=1. With sat=1 → `0x8000`, ovf=1. `0xFFFF + 0xFFFF` → `0xFFFE`, ovf=0.
- `0x00FF + 0x0001` → `0x0100`, ovf=0; the carry crosses the segment boundary. `0x1234 − 0x1234` → `0x0000`, ovf=0.
- Back-to-back stream of 8 random ops with `out_ready=1` → results on 8 consecutive cycles starting 2 cycles after the first accept, each matching a golden model, including ovf.
- Stream of 5 ops with `out_ready=0` for cycles 3–6 → `in_ready=0` whenever `out_valid && !out_ready`. `out_sum` is held stable and all 5 results arrive in order exactly once.
- Assert `rst_n=0` mid-stream with 2 ops in flight → `out_valid`/`out_sum`/`out_ovf` go to 0 immediately and no stale result appears. After release, `0x0003 + 0x0004` → `0x0007` after 2 cycles.

Source files
------------

// File: rtl/signed_add_pkg.sv
// signed_add_pkg
// Shared configuration for the pipelined signed adder/subtractor:
//   DEFAULT_SEG  - default carry-lookahead segment width (one pipe stage each)
//   MAX_WIDTH    - largest operand width the helpers below can describe
//   sat_max()    - most positive two's-complement value of a given width
//   sat_min()    - most negative two's-complement value of a given width
//   width_ok()   - elaboration-time legality check of a WIDTH/SEG pair
package signed_add_pkg;

  localparam int DEFAULT_SEG = 8;
  localparam int MAX_WIDTH   = 256;

  // 0..0 0111..1 : lower (width-1) bits set, sign bit clear
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // 0..0 1000..0 : only the sign bit of a width-bit word set
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int width, input int seg);
    return (seg > 0) && (width >= 2) && (width <= MAX_WIDTH) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/signed_addsub_pipe_cla.sv
// cla_segment
// Combinational SEG-bit carry-lookahead adder. Every carry is formed
// directly from generate/propagate terms and the segment carry-in, so no
// carry ripples through the segment.
//   a, b      : segment operands
//   cin       : carry into bit 0
//   sum       : segment sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (needed for signed overflow)
module cla_segment
  import signed_add_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;
  logic [SEG:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Carry into bit idx+1:
  //   g[idx] | p[idx]g[idx-1] | ... | p[idx..0]cin
  function automatic logic la_carry(input logic [SEG-1:0] g, input logic [SEG-1:0] p,
                                    input logic c0, input int idx);
    logic t;
    logic pp;
    t  = g[idx];
    pp = p[idx];
    for (int j = idx - 1; j >= 0; j--) begin
      t  = t | (pp & g[j]);
      pp = pp & p[j];
    end
    return t | (pp & c0);
  endfunction

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < SEG; gi++) begin : g_carry
    assign w_c[gi+1] = la_carry(w_g, w_p, cin, gi);
  end

  assign sum      = w_p ^ w_c[SEG-1:0];
  assign cout     = w_c[SEG];
  assign c_msb_in = w_c[SEG-1];

endmodule

// File: rtl/signed_addsub_pipe.sv
// signed_addsub_pipe
// Pipelined two's-complement adder/subtractor with signed-overflow flag and
// per-operation saturation. The carry chain is cut into NSEG = WIDTH/SEG
// lookahead segments; segment k is resolved in pipe stage k, so latency is
// NSEG cycles and throughput one operation per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake (in_ready = global advance)
//   in_a, in_b           : signed operands
//   in_sub               : 1 = A-B, 0 = A+B
//   in_sat               : 1 = clamp on overflow, 0 = wrap
//   out_valid/out_ready  : output handshake
//   out_sum, out_ovf     : result and signed-overflow flag
module signed_addsub_pipe
  import signed_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int NSEG   = WIDTH / SEG;
  // Inter-stage registers exist only between stages; keep at least one entry.
  localparam int PIPE_N = (NSEG > 1) ? NSEG - 1 : 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  if (!width_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("signed_addsub_pipe: WIDTH must be >= 2 and a multiple of SEG");
  end

  // Per-stage inputs (from the ports for stage 0, else from the previous stage)
  logic [WIDTH-1:0] w_a_in   [NSEG];
  logic [WIDTH-1:0] w_b_in   [NSEG];
  logic [WIDTH-1:0] w_sum_in [NSEG];
  logic             w_c_in   [NSEG];
  logic             w_sat_in [NSEG];
  logic             w_vld_in [NSEG];

  // Inter-stage pipeline registers
  logic [WIDTH-1:0] r_a   [PIPE_N];
  logic [WIDTH-1:0] r_b   [PIPE_N];
  logic [WIDTH-1:0] r_sum [PIPE_N];
  logic             r_c   [PIPE_N];
  logic             r_sat [PIPE_N];
  logic             r_vld [NSEG];

  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_ovf;
  logic             w_adv;

  // The whole pipe moves in lockstep; bubbles are carried, never squeezed out.
  assign w_adv     = !r_vld[NSEG-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[NSEG-1];
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
    logic [SEG-1:0]   w_seg_sum;
    logic             w_seg_cout;
    logic             w_seg_cmsb;
    logic [WIDTH-1:0] w_sum_out;

    if (gi == 0) begin : g_src_port
      // Subtraction is A + ~B + 1: invert B here, the +1 is the carry-in.
      assign w_a_in[gi]   = in_a;
      assign w_b_in[gi]   = in_sub ? ~in_b : in_b;
      assign w_sum_in[gi] = '0;
      assign w_c_in[gi]   = in_sub;
      assign w_sat_in[gi] = in_sat;
      assign w_vld_in[gi] = in_valid;
    end else begin : g_src_pipe
      assign w_a_in[gi]   = r_a[gi-1];
      assign w_b_in[gi]   = r_b[gi-1];
      assign w_sum_in[gi] = r_sum[gi-1];
      assign w_c_in[gi]   = r_c[gi-1];
      assign w_sat_in[gi] = r_sat[gi-1];
      assign w_vld_in[gi] = r_vld[gi-1];
    end

    cla_segment #(.SEG(SEG)) u_cla (
      .a        (w_a_in[gi][gi*SEG +: SEG]),
      .b        (w_b_in[gi][gi*SEG +: SEG]),
      .cin      (w_c_in[gi]),
      .sum      (w_seg_sum),
      .cout     (w_seg_cout),
      .c_msb_in (w_seg_cmsb)
    );

    // Bits of this segment are still zero in the forwarded partial sum.
    assign w_sum_out = w_sum_in[gi] | (WIDTH'(w_seg_sum) << (gi * SEG));

    if (gi < NSEG - 1) begin : g_mid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld[gi] <= 1'b0;
          r_a[gi]   <= '0;
          r_b[gi]   <= '0;
          r_sum[gi] <= '0;
          r_c[gi]   <= 1'b0;
          r_sat[gi] <= 1'b0;
        end else if (w_adv) begin
          r_vld[gi] <= w_vld_in[gi];
          r_a[gi]   <= w_a_in[gi];
          r_b[gi]   <= w_b_in[gi];
          r_sum[gi] <= w_sum_out;
          r_c[gi]   <= w_seg_cout;
          r_sat[gi] <= w_sat_in[gi];
        end
      end
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;

      assign w_ovf = w_seg_cmsb ^ w_seg_cout;

      // On overflow the true result has A's sign, so clamp toward it.
      always_comb begin
        w_res = w_sum_out;
        if (w_sat_in[gi] && w_ovf) begin
          w_res = w_a_in[gi][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld[gi] <= 1'b0;
          r_out_sum <= '0;
          r_out_ovf <= 1'b0;
        end else if (w_adv) begin
          r_vld[gi] <= w_vld_in[gi];
          r_out_sum <= w_res;
          r_out_ovf <= w_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Directed bench for signed_addsub_pipe at WIDTH=16, SEG=8 (latency 2).
module tb_signed_addsub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  signed_addsub_pipe #(.WIDTH(W), .SEG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: overflow when operand signs agree and the result sign differs.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic sat);
    logic [15:0] be;
    logic [15:0] s;
    logic        ov;
    be = sub ? ~b : b;
    s  = a + be + {15'd0, sub};
    ov = (a[15] == be[15]) && (s[15] != a[15]);
    if (sat && ov) s = a[15] ? 16'h8000 : 16'h7FFF;
    return {ov, s};
  endfunction

  // One isolated operation: accept, check the bubble, then check the result.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat,
                        input logic [15:0] es, input logic eo);
    in_a = a; in_b = b; in_sub = sub; in_sat = sat; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " latency1 valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"}, 32'(out_sum), 32'(es));
    check({tag, " ovf"}, 32'(out_ovf), 32'(eo));
    $display("op %s: a=%h b=%h sub=%0d sat=%0d -> sum=%h ovf=%0d", tag, a, b, sub, sat, out_sum, out_ovf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] sa[5];
    logic [15:0] sb[5];
    logic        ssub[5];
    logic        ssat[5];
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rsub;
    logic        rsat;
    logic        acc;
    logic        fire;
    logic        have_hold;
    logic [15:0] hold_sum;
    logic        hold_ovf;
    int          idx;
    int          recv;

    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_ovf", 32'(out_ovf), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases, expected values worked out by hand
    single("7FFF+1 wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1);
    single("7FFF+1 sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    single("8000-1 wrap", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1);
    single("8000-1 sat",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1);
    single("FFFF+FFFF",   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b0);
    single("FFFF+FFFF sat", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    single("00FF+1 carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    single("1234-1234",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0);
    single("8000+8000 sat", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1);

    // Back-to-back stream of 8 operations, sink always ready
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rsub = 1'($urandom); rsat = 1'($urandom);
        if (n == 0) begin ra = 16'h7000; rb = 16'h7000; rsub = 1'b0; rsat = 1'b1; end
        if (n == 1) begin ra = 16'h9000; rb = 16'h7000; rsub = 1'b1; rsat = 1'b0; end
        in_a = ra; in_b = rb; in_sub = rsub; in_sat = rsat; in_valid = 1'b1;
        e = model(ra, rb, rsub, rsat);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (n < 8) check("stream in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (acc) q.push_back(e);
      check("stream out_valid", 32'(out_valid), 32'((n >= 1) && (n <= 8)));
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("stream sum", 32'(out_sum), 32'(e[15:0]));
          check("stream ovf", 32'(out_ovf), 32'(e[16]));
          $display("stream cycle %0d: sum=%h ovf=%0d", n, out_sum, out_ovf);
        end else begin
          check("stream unexpected result", 32'(out_valid), 32'd0);
        end
      end
    end

    // Stream of 5 with the sink stalled on cycles 3..6
    sa   = '{16'h0102, 16'h7FF0, 16'h8001, 16'h4000, 16'hABCD};
    sb   = '{16'h0304, 16'h0020, 16'h0005, 16'h4000, 16'h1111};
    ssub = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ssat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    idx = 0; recv = 0; have_hold = 1'b0; hold_sum = '0; hold_ovf = 1'b0;
    for (int n = 0; n < 40; n++) begin
      out_ready = !((n >= 3) && (n <= 6));
      if (idx < 5) begin
        in_a = sa[idx]; in_b = sb[idx]; in_sub = ssub[idx]; in_sat = ssat[idx]; in_valid = 1'b1;
        e = model(sa[idx], sb[idx], ssub[idx], ssat[idx]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("stall in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (n == 4) check("stall in_ready low", 32'(in_ready), 32'd0);
      if (have_hold) begin
        check("stall held valid", 32'(out_valid), 32'd1);
        check("stall held sum", 32'(out_sum), 32'(hold_sum));
        check("stall held ovf", 32'(out_ovf), 32'(hold_ovf));
      end
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        if (q.size() > 0) begin
          logic [16:0] x;
          x = q.pop_front();
          check("stall sum", 32'(out_sum), 32'(x[15:0]));
          check("stall ovf", 32'(out_ovf), 32'(x[16]));
          $display("stall result %0d: sum=%h ovf=%0d", recv, out_sum, out_ovf);
        end else begin
          check("stall duplicate result", 32'(out_valid), 32'd0);
        end
        recv++;
      end
      have_hold = out_valid && !out_ready;
      hold_sum  = out_sum;
      hold_ovf  = out_ovf;
      @(posedge clk); #1;
      if (acc) begin
        q.push_back(e);
        idx++;
      end
      if (recv == 5 && idx == 5) break;
    end
    check("stall result count", 32'(recv), 32'd5);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("stall drained", 32'(out_valid), 32'd0);
    end

    // Reset with two operations in flight
    in_a = 16'h0010; in_b = 16'h0020; in_sub = 1'b0; in_sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0100; in_b = 16'h0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset valid", 32'(out_valid), 32'd1);
    check("pre-reset sum", 32'(out_sum), 32'h0030);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_sum", 32'(out_sum), 32'd0);
    check("async reset out_ovf", 32'(out_ovf), 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd1);
    $display("reset asserted mid-stream: out_valid=%0d out_sum=%h", out_valid, out_sum);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no stale after reset", 32'(out_valid), 32'd0);
    end
    single("post-reset 3+4", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
